adc_scan_ctrl: RTL
==================

// Module: adc_scan_ctrl
// PURPOSE
//  Sequences the 16-bit SPI master to scan the ADC wing's multiplexed channels (ADC128S102-style framing).
//  Builds each command frame, pulses start, waits for new_data and extracts the 12-bit result.
//  The ADC pipelines its results: the data read in frame k belongs to the channel addressed in frame k-1.
//  Sits between the SPI master and downstream sample consumers (UART dump, LED bar, capture RAM).
// PARAMETERS
//  NUM_CH     8     number of ADC channels (ch_mask width)
//  CH_BITS    3     channel index width; log2(NUM_CH)
//  ADDR_LSB   11    LSB of the channel-address field in the TX frame (field = [ADDR_LSB+CH_BITS-1:ADDR_LSB])
//  DATA_W     12    result width, taken from RX frame bits [DATA_W-1:0]
//  SCAN_DIV   1000  clocks between scan starts in continuous mode (>= 2)
//  TIMEOUT    255   max clocks from spi_start to spi_new_data before abort
// PORTS
//  clk           in   1        system clock
//  rst_n         in   1        asynchronous active-low reset
//  enable        in   1        continuous scanning: a scan starts every SCAN_DIV clocks
//  single        in   1        1-cycle pulse: one scan when enable=0 and the block is idle
//  ch_mask       in   NUM_CH   channel enable bits; sampled at scan start
//  spi_start     out  1        1-cycle start pulse to the SPI master
//  spi_data_in   out  16       TX frame to the SPI master: channel index in the address field, rest 0
//  spi_data_out  in   16       RX frame from the SPI master
//  spi_busy      in   1        SPI master busy
//  spi_new_data  in   1        1-cycle pulse: spi_data_out is valid
//  sample_valid  out  1        1-cycle pulse: sample_ch/sample_data are valid
//  sample_ch     out  CH_BITS  channel of the presented sample
//  sample_data   out  DATA_W   conversion result
//  scan_done     out  1        1-cycle pulse after the last sample of a scan
//  busy          out  1        high from scan start until return to IDLE
//  error         out  1        1-cycle pulse on timeout abort
// BEHAVIOUR
//  - Reset: all outputs are 0, FSM=IDLE, period counter=0, latched mask=0. Reset mid-frame drops spi_start immediately.
//  - Period counter (runs while enable=1): on reaching 0 it reloads SCAN_DIV-1 and raises a scan request.
//    - The request is held until the FSM is in IDLE. If a scan is still running, at most one request is held pending; extras are dropped.
//    - enable 0->1 raises a request on the next cycle.
//  - single is honoured only when enable=0 and the FSM is in IDLE. Otherwise it is ignored.
//  - Scan start in IDLE: latch ch_mask. If the latched mask is 0, no scan runs, busy stays 0 and scan_done is not pulsed.
//    Otherwise set busy=1, clear first_flag, and go to ISSUE.
//  - FSM states: IDLE, ISSUE, WAIT_DONE, STORE.
//    - ISSUE: when spi_busy=0, drive spi_data_in with the next enabled channel and pulse spi_start for 1 cycle.
//      Reset the timeout counter and go to WAIT_DONE. While spi_busy=1, hold in ISSUE.
//    - WAIT_DONE: on spi_new_data go to STORE. If the timeout counter reaches TIMEOUT, pulse error and go to IDLE
//      (busy=0, no scan_done, pending request kept).
//    - STORE: the first frame of a scan is a dummy; its data is discarded.
//      Every later frame outputs sample_ch = previously addressed channel and sample_data = spi_data_out[DATA_W-1:0],
//      with sample_valid pulsed for 1 cycle. Then go back to ISSUE, or finish (see frame order).
//  - Frame order: enabled channels in ascending index, then one trailing frame that re-addresses the lowest enabled channel
//    to flush the pipeline. A scan of N enabled channels is N+1 frames and produces N samples.
//  - On the STORE of the trailing frame, pulse scan_done in the same cycle as the last sample_valid, then go to IDLE with busy=0.
//  - spi_data_in holds its value from the spi_start cycle until the next ISSUE.
//  - Changing ch_mask or enable mid-scan has no effect on the current scan. It always completes unless it times out or is reset.
//  - spi_new_data outside WAIT_DONE is ignored.
//  - Channel index search wraps: the search for the next enabled bit starts at the current index + 1.
// TESTING
//  1 Reset: rst_n=0 mid-frame -> spi_start=0, busy=0, sample_valid=0 within the same cycle; no samples after release.
//  2 single, ch_mask=8'b0000_0101, SPI model echoing RX=16'h0ABC|ch<<12 -> 3 frames addressing ch 0,2,0.
//    Required: samples (0,12'hABC) then (2,12'hABC); scan_done together with the second sample.
//  3 enable=1, SCAN_DIV=1000, mask=8'hFF -> spi_start pulses exactly 9 per scan; scan starts 1000 clocks apart; 8 samples per scan.
//  4 SPI model never sends new_data -> error pulses TIMEOUT clocks after spi_start; busy=0 afterwards.
//    A following single scan completes normally.
//  5 ch_mask=0 with single -> no spi_start, busy=0, no scan_done.
//  6 spi_busy held high for 50 clocks at ISSUE -> spi_start is delayed until spi_busy=0; sample ordering unchanged.

Source files
------------

// File: rtl/adc_scan_ctrl.sv
// adc_scan_ctrl: scans the enabled ADC channels through a 16-bit SPI master.
// Every scan issues N+1 frames for N enabled channels, because the ADC pipelines
// its results. The first frame's data is discarded. The trailing frame re-addresses
// the lowest enabled channel so that the last channel's result is flushed out.
module adc_scan_ctrl #(
  parameter int NUM_CH   = 8,
  parameter int CH_BITS  = 3,
  parameter int ADDR_LSB = 11,
  parameter int DATA_W   = 12,
  parameter int SCAN_DIV = 1000,
  parameter int TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                single,
  input  logic [NUM_CH-1:0]   ch_mask,
  output logic                spi_start,
  output logic [15:0]         spi_data_in,
  input  logic [15:0]         spi_data_out,
  input  logic                spi_busy,
  input  logic                spi_new_data,
  output logic                sample_valid,
  output logic [CH_BITS-1:0]  sample_ch,
  output logic [DATA_W-1:0]   sample_data,
  output logic                scan_done,
  output logic                busy,
  output logic                error
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, STORE} state_t;

  state_t              state_reg, state_next;
  logic [DIV_W-1:0]    period_cnt_reg;
  logic                req_reg;
  logic                tick;
  logic                start_req;
  logic                scan_go;
  logic [NUM_CH-1:0]   mask_reg;
  logic [CH_BITS-1:0]  cur_ch_reg;      // channel addressed by the latest frame
  logic [CH_BITS-1:0]  prev_ch_reg;     // channel whose result arrives in the latest frame
  logic [CH_BITS-1:0]  next_ch;
  logic                next_wraps;
  logic                first_flag_reg;  // set once the dummy first frame has been consumed
  logic                trailing_reg;    // the frame in flight is the pipeline-flush frame
  logic [TO_W-1:0]     to_cnt_reg;
  logic                timeout_hit;
  logic [DATA_W-1:0]   rx_reg;
  logic [15:0]         frame;
  logic                spi_start_next;
  logic                sample_valid_next;
  logic                scan_done_next;
  logic                error_next;
  logic                busy_next;
  logic                unused_rx_bits;

  // Only the result field of the RX frame carries information we use.
  assign unused_rx_bits = ^spi_data_out[15:DATA_W];

  // A period tick fires whenever the counter sits at 0 while enabled; since the counter
  // is parked at 0 while disabled, enable 0->1 ticks on the first enabled clock.
  assign tick        = enable && (period_cnt_reg == '0);
  assign start_req   = (state_reg == IDLE) && (req_reg || (single && !enable));
  assign scan_go     = start_req && (ch_mask != '0);
  assign timeout_hit = (to_cnt_reg == TO_W'(TIMEOUT - 1));

  // Period counter: reloads SCAN_DIV-1 on each tick, parked at 0 while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_cnt_reg <= '0;
    end else if (!enable) begin
      period_cnt_reg <= '0;
    end else if (tick) begin
      period_cnt_reg <= DIV_W'(SCAN_DIV - 1);
    end else begin
      period_cnt_reg <= period_cnt_reg - 1'b1;
    end
  end

  // Single-entry request latch: a tick is held until IDLE consumes it; extra ticks merge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_reg <= 1'b0;
    end else begin
      req_reg <= tick || (req_reg && (state_reg != IDLE));
    end
  end

  // Wrapping search for the next enabled channel, starting at the current index + 1.
  always_comb begin
    next_ch = cur_ch_reg;
    for (int off = NUM_CH; off >= 1; off--) begin
      if (mask_reg[CH_BITS'(cur_ch_reg + CH_BITS'(off))]) begin
        next_ch = CH_BITS'(cur_ch_reg + CH_BITS'(off));
      end
    end
    // After the first frame, a search that does not move upward has wrapped back to
    // the lowest channel: that is the trailing flush frame.
    next_wraps = first_flag_reg && (next_ch <= cur_ch_reg);
  end

  // TX frame: channel index in the address field, all other bits zero.
  always_comb begin
    frame = '0;
    frame[ADDR_LSB +: CH_BITS] = next_ch;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (scan_go) state_next = ISSUE;
      ISSUE:     if (!spi_busy) state_next = WAIT_DONE;
      WAIT_DONE: begin
        if (spi_new_data) begin
          state_next = STORE;
        end else if (timeout_hit) begin
          state_next = IDLE;
        end
      end
      STORE:     state_next = (first_flag_reg && trailing_reg) ? IDLE : ISSUE;
      default:   state_next = IDLE;
    endcase
  end

  // FSM output decode: next values of the registered strobes and busy flag.
  always_comb begin
    spi_start_next    = 1'b0;
    sample_valid_next = 1'b0;
    scan_done_next    = 1'b0;
    error_next        = 1'b0;
    busy_next         = busy;
    case (state_reg)
      IDLE:      if (scan_go) busy_next = 1'b1;
      ISSUE:     if (!spi_busy) spi_start_next = 1'b1;
      WAIT_DONE: begin
        if (!spi_new_data && timeout_hit) begin
          error_next = 1'b1;
          busy_next  = 1'b0;
        end
      end
      STORE: begin
        if (first_flag_reg) begin
          sample_valid_next = 1'b1;
          if (trailing_reg) begin
            scan_done_next = 1'b1;
            busy_next      = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  // Registered outputs and scan datapath (mask, channel pointers, timeout, RX capture).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_start      <= 1'b0;
      spi_data_in    <= '0;
      sample_valid   <= 1'b0;
      sample_ch      <= '0;
      sample_data    <= '0;
      scan_done      <= 1'b0;
      busy           <= 1'b0;
      error          <= 1'b0;
      mask_reg       <= '0;
      cur_ch_reg     <= '0;
      prev_ch_reg    <= '0;
      first_flag_reg <= 1'b0;
      trailing_reg   <= 1'b0;
      to_cnt_reg     <= '0;
      rx_reg         <= '0;
    end else begin
      spi_start    <= spi_start_next;
      sample_valid <= sample_valid_next;
      scan_done    <= scan_done_next;
      error        <= error_next;
      busy         <= busy_next;

      if (start_req) begin
        mask_reg <= ch_mask;
      end
      if (scan_go) begin
        first_flag_reg <= 1'b0;
        // Parking the pointer on the top index makes the first search begin at 0.
        cur_ch_reg     <= CH_BITS'(NUM_CH - 1);
      end

      if ((state_reg == ISSUE) && !spi_busy) begin
        spi_data_in  <= frame;
        prev_ch_reg  <= cur_ch_reg;
        cur_ch_reg   <= next_ch;
        trailing_reg <= next_wraps;
        to_cnt_reg   <= '0;
      end

      if (state_reg == WAIT_DONE) begin
        to_cnt_reg <= to_cnt_reg + 1'b1;
        if (spi_new_data) begin
          rx_reg <= spi_data_out[DATA_W-1:0];
        end
      end

      if (state_reg == STORE) begin
        first_flag_reg <= 1'b1;
        if (first_flag_reg) begin
          sample_ch   <= prev_ch_reg;
          sample_data <= rx_reg;
        end
      end
    end
  end

endmodule
